// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Holds the fetch PC and drives the instruction-memory address. Registers the
// fetched word, its PC and PC+4 toward decode. Applies execute redirects, and
// hazard-unit stalls and flushes. A redirect seen while fetch is stalled is
// parked until the stall releases.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall_f, stall_d  hold PC / hold IF/ID (hazard unit)
//   flush_d           replace IF/ID contents with a bubble
//   pc_src, pc_target redirect request and target from execute
//   imem_addr         instruction-memory address (= pc_f)
//   imem_rdata        instruction word, combinational read of imem_addr
//   pc_f              current fetch PC
//   instr_d, pc_d, pc_plus4_d, valid_d   IF/ID register outputs
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_007F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_f,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  localparam int unsigned ILEN = 32;

  logic [XLEN-1:0] r_pc;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_target;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc_plus4_d;
  logic            r_valid_d;

  logic [XLEN-1:0] w_eff_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;

  // Word-aligned redirect target; low bits are dropped rather than trapped.
  assign w_eff_target = {pc_target[XLEN-1:2], 2'b00};
  assign w_pc_plus4   = r_pc + XLEN'(4);

  // PC selection: a live redirect outranks a parked one.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (pc_src) begin
      w_pc_next = w_eff_target;
    end else if (r_pend_valid) begin
      w_pc_next = r_pend_target;
    end
  end

  // Fetch PC and parked-redirect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (stall_f) begin
      if (pc_src) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_eff_target;
      end
    end else begin
      r_pc         <= w_pc_next;
      r_pend_valid <= 1'b0;
    end
  end

  // IF/ID register: flush beats stall beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr      <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (flush_d) begin
      r_instr      <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (!stall_d) begin
      r_instr      <= imem_rdata;
      r_pc_d       <= r_pc;
      r_pc_plus4_d <= w_pc_plus4;
      r_valid_d    <= 1'b1;
    end
  end

  assign imem_addr  = r_pc;
  assign pc_f       = r_pc;
  assign instr_d    = r_instr;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_007F;

  logic        clk;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src;
  logic [31:0] pc_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc_f       (pc_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: word N at address 4N for low memory, hashed above.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a < 32'd512) return {25'd0, a[8:2]};
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] p4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference: architectural fetch state plus a list of parked redirect targets.
  logic [31:0] m_pc;
  logic [31:0] m_parked[$];
  exp_t        m_ifid;

  task automatic model_reset();
    m_pc     = 32'h0;
    m_parked.delete();
    m_ifid   = '{pc: 32'h0, instr: NOP, pcd: 32'h0, p4: 32'h0, valid: 1'b0};
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp("pc_f",       pc_f,              e.pc);
    cmp("imem_addr",  imem_addr,         e.pc);
    cmp("instr_d",    instr_d,           e.instr);
    cmp("pc_d",       pc_d,              e.pcd);
    cmp("pc_plus4_d", pc_plus4_d,        e.p4);
    cmp("valid_d",    {31'd0, valid_d},  {31'd0, e.valid});
  endtask

  // One cycle of stimulus: drive, predict post-edge state, enqueue, advance.
  task automatic cyc(input logic sf, input logic sd, input logic fl,
                     input logic ps, input logic [31:0] tgt);
    logic [31:0] aligned;
    logic [31:0] nxt_pc;
    exp_t        e;
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src = ps; pc_target = tgt;
    aligned = tgt & 32'hFFFF_FFFC;
    if (sf) begin
      nxt_pc = m_pc;
      if (ps) begin
        m_parked.delete();
        m_parked.push_back(aligned);
      end
    end else begin
      if (ps)                    nxt_pc = aligned;
      else if (m_parked.size())  nxt_pc = m_parked[0];
      else                       nxt_pc = m_pc + 32'd4;
      m_parked.delete();
    end
    if (fl)       m_ifid = '{pc: 32'h0, instr: NOP, pcd: 32'h0, p4: 32'h0, valid: 1'b0};
    else if (!sd) m_ifid = '{pc: 32'h0, instr: imem_word(m_pc), pcd: m_pc,
                             p4: m_pc + 32'd4, valid: 1'b1};
    m_pc   = nxt_pc;
    e      = m_ifid;
    e.pc   = m_pc;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: the IF/ID register and PC update every edge; compare shortly after.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check_all(exp_q.pop_front());
  end

  exp_t rst_exp;

  initial begin
    rst = 1'b1;
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src = 0; pc_target = 0;
    model_reset();
    rst_exp = '{pc: 32'h0, instr: NOP, pcd: 32'h0, p4: 32'h0, valid: 1'b0};
    #1;
    check_all(rst_exp);
    @(posedge clk); #2;
    rst = 1'b0;

    // Free run from reset, then redirect at pc_f=8 with flush.
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h40);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Full stall for three cycles at pc_f=0x10.
    cyc(0, 0, 1, 1, 32'h10);
    repeat (3) cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Redirects while stalled at 0x20: newest aligned target wins.
    cyc(0, 0, 1, 1, 32'h20);
    cyc(1, 1, 0, 1, 32'h103);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h200);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Live redirect in the release cycle beats the parked one.
    cyc(1, 1, 0, 1, 32'h200);
    cyc(0, 0, 1, 1, 32'h300);
    cyc(0, 0, 0, 0, 0);

    // Flush outranks stall; fetch-only stall refetches the same PC.
    cyc(1, 1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // PC wraps at the top of the address space.
    cyc(0, 0, 1, 1, 32'hFFFF_FFFC);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with a redirect parked.
    cyc(1, 1, 0, 1, 32'h500);
    #1;
    rst = 1'b1;
    #1;
    check_all(rst_exp);
    model_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0);

    // Randomized traffic; stall_d only ever with stall_f.
    for (int i = 0; i < 400; i++) begin
      logic sf, sd, fl, ps;
      logic [31:0] t;
      sf = ($urandom_range(0, 3) == 0);
      sd = sf & ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0) | (ps & ~sf);
      t  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 511)) : $urandom;
      cyc(sf, sd, fl, ps, t);
    end
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src = 0;

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipeline.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched instruction, PC and PC+4 into the decode stage, where the opcode field instr_d[6:0] drives the controller's op input.
- Applies branch/jump redirects from execute, hazard-unit stalls and flushes; a redirect that arrives while fetch is stalled is held until the stall clears.

Parameters:
- XLEN, 32, datapath / PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_007F, bubble instruction inserted on flush/reset. Opcode 7'h7F hits the controller's default case, so all control signals are zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall_f  input  1  hold PC (hazard unit)
- stall_d  input  1  hold IF/ID register (hazard unit)
- flush_d  input  1  replace IF/ID contents with bubble
- pc_src  input  1  redirect request from execute (taken branch / jump / jalr)
- pc_target  input  XLEN  redirect target from execute
- imem_addr  output  XLEN  instruction-memory address (= pc_f)
- imem_rdata  input  32  instruction word; combinational read of imem_addr
- pc_f  output  XLEN  current fetch PC
- instr_d  output  32  registered instruction to decode
- pc_d  output  XLEN  registered PC of instr_d
- pc_plus4_d  output  XLEN  registered pc_d+4 (jal/jalr link value)
- valid_d  output  1  instr_d is a real fetched instruction (0 = bubble)

Behaviour:
- Reset (async, any time, including mid-stall or with a redirect pending):
  - pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - pend_valid=0, pend_target=0.
- imem_addr = pc_f, combinationally; fetch latency is 0 cycles. An instruction at pc_f appears on instr_d at the next rising edge unless stalled or flushed.
- Redirect target: eff_target = {target[XLEN-1:2], 2'b00}; the low bits are always cleared. No misalignment trap.
- Pending redirect register (pend_valid, pend_target):
  - pc_src=1 and stall_f=1: capture pend_valid=1, pend_target=eff_target(pc_target). A newer pc_src overwrites an older pending target.
  - stall_f=0: pend_valid clears at the edge (pending consumed or none present).
- PC next-state, evaluated in priority order:
  1. stall_f=1: hold.
  2. pc_src=1: eff_target(pc_target). A live request beats a pending one.
  3. pend_valid=1: pend_target.
  4. Otherwise pc_f+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC+4 = 0).
- IF/ID register update, priority flush > stall > load:
  - flush_d=1: instr_d=NOP_INSTR, valid_d=0, pc_d=0, pc_plus4_d=0. This also applies when stall_d=1.
  - stall_d=1: hold all four outputs.
  - Otherwise: instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
- Stall pairing:
  - The hazard unit normally asserts stall_f and stall_d together.
  - stall_f=1 with stall_d=0 is legal: the same pc_f is fetched into decode again each cycle.
  - stall_d=1 with stall_f=0 is illegal. The PC advances anyway; the block does not check for it.
- Taken redirect with pc_src=1 and stall_f=0: the hazard unit asserts flush_d in the same cycle, squashing the wrong-path instruction. The block itself does not auto-flush.
- Redirect while stalled, cycle by cycle:
  - Cycle 0: pc_src=1, stall_f=1. PC holds, target is latched.
  - First cycle with stall_f=0: PC loads pend_target; pend_valid clears.
- Throughput: one instruction per cycle with no stall or flush.

Test Plan:
- Reset then free-run with imem word = {25'd0, 7'dN} at address 4N: pc_f = 0, 4, 8, …; instr_d lags by one cycle; valid_d 0→1 after the first edge; pc_plus4_d = pc_d+4.
- At pc_f=8, pc_src=1, pc_target=32'h40, flush_d=1: next edge gives pc_f=32'h40, instr_d=32'h7F, valid_d=0. The following edge gives pc_d=32'h40, valid_d=1.
- stall_f=stall_d=1 for 3 cycles at pc_f=32'h10: pc_f and all IF/ID outputs constant. After release, pc_f=32'h14.
- During a stall at pc_f=32'h20:
  - pc_src=1, pc_target=32'h103, then pc_target=32'h200 two cycles later.
  - After release: pc_f=32'h200, with low bits cleared and the newest target winning.
  - pc_src during the release cycle itself (target 32'h300) beats the pending 32'h200.
- flush_d=1 together with stall_d=1: instr_d=32'h7F, valid_d=0. Separately, pc_f=32'hFFFF_FFFC advances to 0.
- rst asserted asynchronously mid-cycle with pend_valid=1: outputs reach reset values immediately, without a clock edge. After deassertion, pc_f fetches from RESET_PC and the pending redirect is discarded.
